// File: rtl/pattern_gen_pkg.sv
// Shared types and constants for the pattern_gen test-pattern source.
// Mode encoding, colour-bar table and pipeline depth.
package pattern_gen_pkg;

    typedef enum logic [2:0] {
        MODE_BLACK   = 3'd0,
        MODE_BARS    = 3'd1,
        MODE_CHECKER = 3'd2,
        MODE_RAMP    = 3'd3,
        MODE_ANIM    = 3'd4,
        MODE_WHITE   = 3'd5,
        MODE_RED     = 3'd6,
        MODE_BORDER  = 3'd7
    } mode_e;

    // {r,g,b} on/off flags: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    localparam int PIPE_LATENCY = 2;

endpackage

// File: rtl/pattern_gen_bar.sv
// Colour-bar position tracker: reports the bar index of the pixel presented
// this cycle; bar width is reloaded from h_active at each frame edge.
module pattern_bar_counter
    import pattern_gen_pkg::*;
#(
    parameter int X_BITS = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              de_in,
    input  logic              load,
    input  logic [X_BITS-1:0] h_active,
    output logic [2:0]        bar_idx
);

    logic [X_BITS-1:0] bar_w_q, bar_w_d;
    logic [X_BITS-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]        bar_idx_q, bar_idx_d;
    logic              de_prev_q;

    always_comb begin
        bar_w_d   = bar_w_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (load) begin
            bar_w_d = h_active >> 3;
            if (bar_w_d == '0) bar_w_d = X_BITS'(1);
        end
        if (de_in && !de_prev_q) begin
            bar_cnt_d = X_BITS'(1);
            bar_idx_d = 3'd0;
        end else if (de_in) begin
            if (bar_cnt_q == bar_w_q) begin
                bar_cnt_d = X_BITS'(1);
                if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + X_BITS'(1);
            end
        end
    end

    // the index for the current pixel is the freshly computed one
    assign bar_idx = bar_idx_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bar_w_q   <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            de_prev_q <= 1'b0;
        end else begin
            bar_w_q   <= bar_w_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            de_prev_q <= de_in;
        end
    end

endmodule

// File: rtl/pattern_gen.sv
// Test-pattern pixel source with a fixed 2-cycle pipeline behind the sync generator.
// Optional crosshair overlay enabled by PATTERN_GEN_CROSSHAIR_EN.
module pattern_gen
    import pattern_gen_pkg::*;
#(
    parameter int X_BITS     = 12,
    parameter int Y_BITS     = 12,
    parameter int COLOR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vs_in,
    input  logic                  hs_in,
    input  logic                  de_in,
    input  logic [X_BITS-1:0]     x_in,
    input  logic [Y_BITS-1:0]     y_in,
    input  logic [X_BITS-1:0]     h_active,
    input  logic [Y_BITS-1:0]     v_active,
    input  logic [2:0]            mode_req,
    output logic [2:0]            mode_cur,
    output logic [15:0]           frame_count,
    output logic                  vs_out,
    output logic                  hs_out,
    output logic                  de_out,
    output logic [COLOR_BITS-1:0] r_out,
    output logic [COLOR_BITS-1:0] g_out,
    output logic [COLOR_BITS-1:0] b_out
`ifdef PATTERN_GEN_CROSSHAIR_EN
    ,
    input  logic [X_BITS-1:0]     cursor_x,
    input  logic [Y_BITS-1:0]     cursor_y,
    input  logic                  cursor_en
`endif
);

    localparam logic [COLOR_BITS-1:0] FULL = '1;

    logic                    vs_prev_q;
    logic                    frame_edge;
    mode_e                   mode_cur_q, mode_cur_d;
    logic [15:0]             frame_count_q, frame_count_d;
    logic [2:0]              bar_idx;
    logic [2:0]              bar_rgb;
    logic [PIPE_LATENCY-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_LATENCY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_LATENCY-1:0] de_pipe_q, de_pipe_d;
    logic [COLOR_BITS-1:0]   r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
    logic [COLOR_BITS-1:0]   r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
    logic                    hit_q, hit_d;

    assign frame_edge = vs_in && !vs_prev_q;

    pattern_bar_counter #(.X_BITS(X_BITS)) u_bar (
        .clk      (clk),
        .reset_n  (reset_n),
        .de_in    (de_in),
        .load     (frame_edge),
        .h_active (h_active),
        .bar_idx  (bar_idx)
    );

    assign bar_rgb = BAR_RGB[bar_idx];

    always_comb begin
        mode_cur_d    = mode_cur_q;
        frame_count_d = frame_count_q;
        if (frame_edge) begin
            mode_cur_d    = mode_e'(mode_req);
            frame_count_d = frame_count_q + 16'd1;
        end
        vs_pipe_d = {vs_pipe_q[PIPE_LATENCY-2:0], vs_in};
        hs_pipe_d = {hs_pipe_q[PIPE_LATENCY-2:0], hs_in};
        de_pipe_d = {de_pipe_q[PIPE_LATENCY-2:0], de_in};
    end

    // stage 1: raw pattern colour, blanking is applied in stage 2
    always_comb begin
        r1_d  = '0;
        g1_d  = '0;
        b1_d  = '0;
        hit_d = 1'b0;
        case (mode_cur_q)
            MODE_BLACK: ;
            MODE_BARS: begin
                r1_d = {COLOR_BITS{bar_rgb[2]}};
                g1_d = {COLOR_BITS{bar_rgb[1]}};
                b1_d = {COLOR_BITS{bar_rgb[0]}};
            end
            MODE_CHECKER: begin
                if (x_in[5] ^ y_in[5]) begin
                    r1_d = FULL; g1_d = FULL; b1_d = FULL;
                end
            end
            MODE_RAMP: begin
                r1_d = x_in[COLOR_BITS-1:0];
                g1_d = x_in[COLOR_BITS-1:0];
                b1_d = x_in[COLOR_BITS-1:0];
            end
            MODE_ANIM: begin
                r1_d = x_in[COLOR_BITS-1:0] + frame_count_q[COLOR_BITS-1:0];
                g1_d = y_in[COLOR_BITS-1:0] + frame_count_q[COLOR_BITS-1:0];
                b1_d = x_in[COLOR_BITS-1:0] ^ y_in[COLOR_BITS-1:0];
            end
            MODE_WHITE: begin
                r1_d = FULL; g1_d = FULL; b1_d = FULL;
            end
            MODE_RED: r1_d = FULL;
            MODE_BORDER: begin
                if (x_in == '0 || y_in == '0 ||
                    x_in == h_active - X_BITS'(1) || y_in == v_active - Y_BITS'(1)) begin
                    r1_d = FULL; g1_d = FULL; b1_d = FULL;
                end
            end
        endcase
`ifdef PATTERN_GEN_CROSSHAIR_EN
        hit_d = cursor_en && (x_in == cursor_x || y_in == cursor_y);
`endif
    end

    always_comb begin
        r2_d = '0;
        g2_d = '0;
        b2_d = '0;
        if (de_pipe_q[0]) begin
            r2_d = r1_q ^ {COLOR_BITS{hit_q}};
            g2_d = g1_q ^ {COLOR_BITS{hit_q}};
            b2_d = b1_q ^ {COLOR_BITS{hit_q}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev_q     <= 1'b0;
            mode_cur_q    <= MODE_BLACK;
            frame_count_q <= '0;
            vs_pipe_q     <= '0;
            hs_pipe_q     <= '0;
            de_pipe_q     <= '0;
            r1_q          <= '0;
            g1_q          <= '0;
            b1_q          <= '0;
            hit_q         <= 1'b0;
            r2_q          <= '0;
            g2_q          <= '0;
            b2_q          <= '0;
        end else begin
            vs_prev_q     <= vs_in;
            mode_cur_q    <= mode_cur_d;
            frame_count_q <= frame_count_d;
            vs_pipe_q     <= vs_pipe_d;
            hs_pipe_q     <= hs_pipe_d;
            de_pipe_q     <= de_pipe_d;
            r1_q          <= r1_d;
            g1_q          <= g1_d;
            b1_q          <= b1_d;
            hit_q         <= hit_d;
            r2_q          <= r2_d;
            g2_q          <= g2_d;
            b2_q          <= b2_d;
        end
    end

    assign mode_cur    = mode_cur_q;
    assign frame_count = frame_count_q;
    assign vs_out      = vs_pipe_q[PIPE_LATENCY-1];
    assign hs_out      = hs_pipe_q[PIPE_LATENCY-1];
    assign de_out      = de_pipe_q[PIPE_LATENCY-1];
    assign r_out       = r2_q;
    assign g_out       = g2_q;
    assign b_out       = b2_q;

endmodule
